// File: rtl/mips_single_cycle_pkg.sv
// Shared constants and decode types for the single-cycle MIPS core.
// Opcode/funct encodings, memory geometry and the control enums used by the top.
package mips_single_cycle_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;

  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam int unsigned ImDepth = 1024;
  localparam int unsigned DmDepth = 1024;

  typedef enum logic [1:0] {AluAdd, AluSub, AluOr, AluLui} alu_op_e;
  typedef enum logic [1:0] {NpcSeq, NpcBranch, NpcJump, NpcReg} npc_sel_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbLink} wb_sel_e;

  function automatic logic [31:0] sext16(logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_single_cycle_grf.sv
// 32x32 general register file: two combinational read ports, one write port.
// $0 is hardwired to zero; every write attempt is traced in simulation.
module mips_single_cycle_grf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] rf_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      if (wa_i != 5'd0) rf_q[wa_i] <= wd_i;
`ifndef SYNTHESIS
      $display("@%h: $%d <= %h", pc_i, wa_i, wd_i);
`endif
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : rf_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : rf_q[ra2_i];

  logic unused_pc;
  assign unused_pc = ^pc_i;

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS core: fetch, decode, execute and write back one instruction per clock.
// Instruction memory is loaded hierarchically; data memory is word-addressed by addr[11:2].
module mips_single_cycle
  import mips_single_cycle_pkg::*;
(
  input logic clk,
  input logic reset
);

  logic [31:0] pc_q, pc_d, pc_plus4, pc_off, instr;
  logic [31:0] im [ImDepth];
  logic [31:0] dm_q [DmDepth];

  assign pc_off   = pc_q - ResetPc;
  assign instr    = im[pc_off[11:2]];
  assign pc_plus4 = pc_q + 32'd4;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] instr_index;

  assign opcode      = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign funct       = instr[5:0];
  assign imm16       = instr[15:0];
  assign instr_index = instr[25:0];

  logic [31:0] rd1, rd2, imm_ext, alu_b, alu_res, dm_rdata, wd;
  logic        reg_we, mem_we, use_imm;
  logic [4:0]  wa;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  npc_sel_e    npc_sel;

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    use_imm = 1'b0;
    imm_ext = sext16(imm16);
    wa      = rt;
    alu_op  = AluAdd;
    wb_sel  = WbAlu;
    npc_sel = NpcSeq;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAddu: begin reg_we = 1'b1; wa = rd; end
          FnSubu: begin reg_we = 1'b1; wa = rd; alu_op = AluSub; end
          FnJr:   npc_sel = NpcReg;
          default: ;
        endcase
      end
      OpOri: begin
        reg_we  = 1'b1;
        use_imm = 1'b1;
        imm_ext = {16'h0, imm16};
        alu_op  = AluOr;
      end
      OpLui: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = AluLui; end
      OpLw:  begin reg_we = 1'b1; use_imm = 1'b1; wb_sel = WbMem; end
      OpSw:  begin mem_we = 1'b1; use_imm = 1'b1; end
      OpBeq: if (rd1 == rd2) npc_sel = NpcBranch;
      OpJ:   npc_sel = NpcJump;
      OpJal: begin reg_we = 1'b1; wa = 5'd31; wb_sel = WbLink; npc_sel = NpcJump; end
      default: ;
    endcase
  end

  assign alu_b = use_imm ? imm_ext : rd2;

  always_comb begin
    unique case (alu_op)
      AluAdd: alu_res = rd1 + alu_b;
      AluSub: alu_res = rd1 - alu_b;
      AluOr:  alu_res = rd1 | alu_b;
      AluLui: alu_res = {imm16, 16'h0};
    endcase
  end

  assign dm_rdata = dm_q[alu_res[11:2]];

  always_comb begin
    case (wb_sel)
      WbMem:   wd = dm_rdata;
      WbLink:  wd = pc_plus4;
      default: wd = alu_res;
    endcase
  end

  always_comb begin
    unique case (npc_sel)
      NpcSeq:    pc_d = pc_plus4;
      NpcBranch: pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
      NpcJump:   pc_d = {pc_q[31:28], instr_index, 2'b00};
      NpcReg:    pc_d = rd1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= ResetPc;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DmDepth); i++) dm_q[i] <= '0;
    end else if (mem_we) begin
      dm_q[alu_res[11:2]] <= rd2;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", pc_q, alu_res, rd2);
`endif
    end
  end

  mips_single_cycle_grf u_grf (
    .clk_i  (clk),
    .rst_ni (reset),
    .pc_i   (pc_q),
    .ra1_i  (rs),
    .ra2_i  (rt),
    .rd1_o  (rd1),
    .rd2_o  (rd2),
    .we_i   (reg_we),
    .wa_i   (wa),
    .wd_i   (wd)
  );

  // Address bits outside the word index and the shamt field play no part in this subset.
  logic unused_bits;
  assign unused_bits = ^{pc_off[31:12], pc_off[1:0], alu_res[31:12], alu_res[1:0], instr[10:6]};

endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: directed program with checkpoint table, async reset
// sequences, then random programs checked against an instruction-level model.
module tb_mips_single_cycle;

  logic clk;
  logic reset;

  mips_single_cycle dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [31:0] m_pc;
  logic [31:0] m_gpr [32];
  logic [31:0] m_dm  [1024];
  logic [31:0] m_im  [1024];

  typedef struct {
    int unsigned cycle;
    int unsigned kind;  // 0 = PC, 1 = register, 2 = DM word
    int unsigned idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t chk[$];
  logic [31:0] dprog [22];

  task automatic add_chk(input int unsigned cyc, input int unsigned kind, input int unsigned idx,
                         input logic [31:0] exp, input string name);
    chk_t c;
    c.cycle = cyc; c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    chk.push_back(c);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h3000;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    for (int i = 0; i < 1024; i++) m_dm[i] = '0;
  endtask

  task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_gpr[r] = v;
  endtask

  // Architectural effect of one instruction, straight from the ISA rules.
  task automatic model_step();
    logic [31:0] ins, a, b, simm, addr, npc;
    logic [9:0]  ia, da;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    ia   = 10'((m_pc - 32'h3000) >> 2);
    ins  = m_im[ia];
    op   = ins[31:26]; fn = ins[5:0];
    rs   = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a    = m_gpr[rs];  b  = m_gpr[rt];
    simm = 32'($signed(ins[15:0]));
    addr = a + simm;
    da   = 10'(addr >> 2);
    npc  = m_pc + 32'd4;
    case (op)
      6'h00: begin
        if (fn == 6'h21)      model_wr(rd, a + b);
        else if (fn == 6'h23) model_wr(rd, a - b);
        else if (fn == 6'h08) npc = a;
      end
      6'h0D: model_wr(rt, a | 32'(ins[15:0]));
      6'h0F: model_wr(rt, 32'(ins[15:0]) << 16);
      6'h23: model_wr(rt, m_dm[da]);
      6'h2B: m_dm[da] = b;
      6'h04: if (a == b) npc = m_pc + 32'd4 + simm * 32'd4;
      6'h02: npc = (m_pc & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
      6'h03: begin
        model_wr(5'd31, m_pc + 32'd4);
        npc = (m_pc & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
      end
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic compare_state(input string tag);
    int bad_r;
    int bad_m;
    bad_r = -1;
    bad_m = -1;
    check({tag, " pc"}, dut.pc_q, m_pc);
    for (int i = 0; i < 32; i++)
      if (bad_r < 0 && dut.u_grf.rf_q[i] !== m_gpr[i]) bad_r = i;
    n_checks++;
    if (bad_r >= 0) begin
      n_errors++;
      $display("FAIL %s grf: $%0d got %h expected %h", tag, bad_r, dut.u_grf.rf_q[bad_r],
               m_gpr[bad_r]);
    end
    for (int i = 0; i < 1024; i++)
      if (bad_m < 0 && dut.dm_q[i] !== m_dm[i]) bad_m = i;
    n_checks++;
    if (bad_m >= 0) begin
      n_errors++;
      $display("FAIL %s dm: word %0d got %h expected %h", tag, bad_m, dut.dm_q[bad_m],
               m_dm[bad_m]);
    end
  endtask

  task automatic run_cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_state(tag);
  endtask

  function automatic logic [4:0] pick_reg();
    int unsigned r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = pick_reg();
    rt  = pick_reg();
    rd  = pick_reg();
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return {6'h0D, rs, rt, imm};
      1:  return {6'h0F, 5'd0, rt, imm};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      4:  return {6'h23, rs, rt, imm};
      5:  return {6'h2B, rs, rt, imm};
      6:  return {6'h04, rs, rt, 16'($urandom_range(0, 6)) - 16'd3};
      7:  return {6'h02, 26'(32'hC00 + $urandom_range(0, 63))};
      8:  return {6'h03, 26'(32'hC00 + $urandom_range(0, 63))};
      9:  return {6'h00, rs, 15'd0, 6'h08};
      10: begin
        case ($urandom_range(0, 3))
          0:       return {6'h08, rs, rt, imm};
          1:       return {6'h05, rs, rt, imm};
          2:       return {6'h00, rs, rt, rd, 5'd0, 6'h20};
          default: return {6'h3F, 26'($urandom)};
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) begin
      m_im[i]   = (i < 22) ? dprog[i] : 32'h0;
      dut.im[i] = m_im[i];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 1024; i++) begin
      m_im[i]   = (i < 64) ? rand_instr() : 32'h0;
      dut.im[i] = m_im[i];
    end
  endtask

  initial begin
    logic [31:0] act;
    n_checks = 0;
    n_errors = 0;

    dprog = '{
      32'h3401_1234,  // 3000 ori  $1,$0,0x1234
      32'h3C02_FFFF,  // 3004 lui  $2,0xFFFF
      32'h3442_FFFF,  // 3008 ori  $2,$2,0xFFFF
      32'h3403_0001,  // 300C ori  $3,$0,1
      32'h1021_0002,  // 3010 beq  $1,$1,+2
      32'h3407_0BAD,  // 3014 skipped
      32'h3407_0BAD,  // 3018 skipped
      32'h0043_2021,  // 301C addu $4,$2,$3
      32'h0C00_0C10,  // 3020 jal  0x3040
      32'h0003_2823,  // 3024 subu $5,$0,$3
      32'h1020_0002,  // 3028 beq  $1,$0,+2
      32'h3400_0005,  // 302C ori  $0,$0,5
      32'hFC00_0000,  // 3030 undefined
      32'h0800_0C14,  // 3034 j    0x3050
      32'h3407_0BAD,  // 3038 skipped
      32'h3407_0BAD,  // 303C skipped
      32'hAC01_0004,  // 3040 sw   $1,4($0)
      32'h3408_0008,  // 3044 ori  $8,$0,8
      32'h8D06_FFFC,  // 3048 lw   $6,-4($8)
      32'h03E0_0008,  // 304C jr   $31
      32'h8C09_0004,  // 3050 lw   $9,4($0)
      32'h1000_FFFF   // 3054 beq  $0,$0,-1
    };

    add_chk(1,  1, 1,  32'h0000_1234, "ori $1");
    add_chk(1,  0, 0,  32'h0000_3004, "pc after ori");
    add_chk(3,  1, 2,  32'hFFFF_FFFF, "lui+ori $2");
    add_chk(5,  0, 0,  32'h0000_301C, "beq taken");
    add_chk(6,  1, 4,  32'h0000_0000, "addu wrap");
    add_chk(7,  1, 31, 32'h0000_3024, "jal link");
    add_chk(7,  0, 0,  32'h0000_3040, "jal target");
    add_chk(8,  2, 1,  32'h0000_1234, "sw word");
    add_chk(10, 1, 6,  32'h0000_1234, "lw -4 from 8");
    add_chk(11, 0, 0,  32'h0000_3024, "jr $31");
    add_chk(12, 1, 5,  32'hFFFF_FFFF, "subu wrap");
    add_chk(13, 0, 0,  32'h0000_302C, "beq not taken");
    add_chk(14, 1, 0,  32'h0000_0000, "write $0");
    add_chk(15, 0, 0,  32'h0000_3034, "undefined op");
    add_chk(16, 0, 0,  32'h0000_3050, "j target");
    add_chk(17, 1, 9,  32'h0000_1234, "lw 4 from 0");
    add_chk(18, 0, 0,  32'h0000_3054, "beq backward");
    add_chk(20, 0, 0,  32'h0000_3054, "beq backward hold");
    add_chk(20, 1, 7,  32'h0000_0000, "skipped ori");

    reset = 1'b1;
    #1 reset = 1'b0;
    #1 load_directed();
    model_reset();
    repeat (2) @(negedge clk);
    compare_state("reset");
    reset = 1'b1;

    for (int unsigned cyc = 1; cyc <= 20; cyc++) begin
      run_cycle("directed");
      foreach (chk[j]) begin
        if (chk[j].cycle == cyc) begin
          case (chk[j].kind)
            0:       act = dut.pc_q;
            1:       act = dut.u_grf.rf_q[chk[j].idx];
            default: act = dut.dm_q[chk[j].idx];
          endcase
          check(chk[j].name, act, chk[j].exp);
        end
      end
    end

    // Reset mid-cycle: state must clear before the next clock edge.
    #2 reset = 1'b0;
    #1 model_reset();
    compare_state("async reset");
    repeat (2) @(negedge clk);
    compare_state("held reset");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) run_cycle("restart");
    check("restart $1", dut.u_grf.rf_q[1], 32'h0000_1234);

    for (int p = 0; p < 4; p++) begin
      reset = 1'b0;
      load_random();
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 150; i++) run_cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
